rle_packer: RTL

Parametrised run-length encoder for the sampler capture path; it sits between the sample synchroniser/trigger stage and the capture memory controller. It generalises the existing fixed 32-bit encoder in three ways: a configurable data width, an inclusive/exclusive count convention, and an explicit flush of a pending run at end of capture. It also adds valid/ready backpressure on both sides, buffered by a small output FIFO.

---
 rtl/rle_pkg.sv | 15 +
 rtl/rle_out_fifo.sv | 62 ++++++
 rtl/rle_packer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared types and width helpers for the run-length packer
package rle_pkg;

  typedef logic [1:0] wr_cnt_t;

  // Modes beyond the last byte lane fall back to the full sample width.
  function automatic int aw_of(input int mode, input int data_width);
    return (mode > data_width / 8 - 1) ? data_width : 8 * (mode + 1);
  endfunction

  function automatic logic [63:0] cmax_of(input int aw);
    return (64'd1 << (aw - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/rle_out_fifo.sv
// rtl/rle_out_fifo.sv - dual-write, single-read output FIFO with free-slot count
module rle_out_fifo
  import rle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  wr_cnt_t                  wr_num,
  input  logic [WIDTH-1:0]         wr_data0,
  input  logic [WIDTH-1:0]         wr_data1,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]       wptr;
  logic [PW:0]       rptr;
  logic [PW:0]       used;
  logic [PW-1:0]     widx0;
  logic [PW-1:0]     widx1;
  logic              empty;
  logic              full;
  logic [WIDTH-1:0]  mem [DEPTH];

  // The extra pointer bit separates full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign used  = wptr - rptr;
  assign free  = full ? '0 : ((PW + 1)'(DEPTH) - used);

  assign widx0    = wptr[PW-1:0];
  assign widx1    = widx0 + PW'(1);
  assign rd_valid = !empty;
  assign rd_data  = rd_valid ? mem[rptr[PW-1:0]] : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (PW + 1)'(wr_num);
      if (rd_en && rd_valid) begin
        rptr <= rptr + (PW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_num != 2'd0) begin
      mem[widx0] <= wr_data0;
    end
    if (wr_num == 2'd2) begin
      mem[widx1] <= wr_data1;
    end
  end

endmodule

// File: rtl/rle_packer.sv
// rtl/rle_packer.sv - run-length encoder with flush and backpressured output FIFO
// Optional statistics counters are built when RLE_STATS_EN is defined.
module rle_packer
  import rle_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int MODE_W     = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [MODE_W-1:0]     mode,
  input  logic                  repeat_mode,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  output logic                  readyIn,
  input  logic                  flush,
  output logic                  flushDone,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  input  logic                  readyOut,
  output logic [31:0]           statSamples,
  output logic [31:0]           statWords
);

  localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  int                    aw;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] flag;
  logic [DATA_WIDTH-1:0] cmax;
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] data_word;
  logic [DATA_WIDTH-1:0] rep_ext;

  logic                  has_last, has_last_n;
  logic [DATA_WIDTH-1:0] last, last_n;
  logic [DATA_WIDTH-1:0] cnt, cnt_n;
  logic                  flush_pend, flush_pend_n;
  logic                  flush_serv;
  logic                  flush_done;

  wr_cnt_t               wr_num;
  logic [DATA_WIDTH-1:0] wd [2];
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_valid;
  logic [FREE_W-1:0]     free;
  logic                  room;
  logic                  take;

  function automatic logic [DATA_WIDTH-1:0] count_word(
    input logic [DATA_WIDTH-1:0] value,
    input logic [DATA_WIDTH-1:0] f,
    input logic [DATA_WIDTH-1:0] m
  );
    return f | (value & m);
  endfunction

  always_comb begin
    aw   = aw_of(32'(mode), DATA_WIDTH);
    cmax = DATA_WIDTH'(cmax_of(aw));
    mask = '0;
    flag = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      mask[i] = (i < aw);
      flag[i] = (i == aw - 1);
    end
  end

  assign sample    = dataIn & mask;
  assign data_word = sample & ~flag;
  assign rep_ext   = {{(DATA_WIDTH-1){1'b0}}, repeat_mode};

  assign room    = (free >= FREE_W'(2));
  assign readyIn = room && reset_n;
  assign take    = validIn && readyIn;

  // A flush left pending by a full FIFO is older than any sample taken with it,
  // so it runs first; a fresh flush runs after the sample of its own cycle.
  always_comb begin
    wr_num       = '0;
    wd[0]        = '0;
    wd[1]        = '0;
    has_last_n   = has_last;
    last_n       = last;
    cnt_n        = cnt;
    flush_serv   = 1'b0;
    flush_pend_n = flush_pend | flush;
    if (room) begin
      if (flush_pend) begin
        if (cnt_n != '0) begin
          wd[wr_num[0]] = count_word(cnt_n + rep_ext, flag, cmax);
          wr_num        = wr_num + 2'd1;
        end
        cnt_n      = '0;
        has_last_n = 1'b0;
        flush_serv = 1'b1;
      end
      if (take) begin
        if (!enable) begin
          wd[wr_num[0]] = sample;
          wr_num        = wr_num + 2'd1;
        end else if (!has_last_n || sample != last_n) begin
          if (has_last_n && cnt_n != '0) begin
            wd[wr_num[0]] = count_word(cnt_n + rep_ext, flag, cmax);
            wr_num        = wr_num + 2'd1;
          end
          wd[wr_num[0]] = data_word;
          wr_num        = wr_num + 2'd1;
          last_n        = sample;
          cnt_n         = '0;
          has_last_n    = 1'b1;
        end else begin
          cnt_n = cnt_n + ONE;
          if (cnt_n + rep_ext == cmax) begin
            wd[wr_num[0]] = count_word(cmax, flag, cmax);
            wr_num        = wr_num + 2'd1;
            cnt_n         = '0;
          end
        end
      end
      if (flush && !flush_pend) begin
        if (cnt_n != '0) begin
          wd[wr_num[0]] = count_word(cnt_n + rep_ext, flag, cmax);
          wr_num        = wr_num + 2'd1;
        end
        cnt_n      = '0;
        has_last_n = 1'b0;
        flush_serv = 1'b1;
      end
      flush_pend_n = flush_pend && flush;
    end
    if (!enable) begin
      has_last_n = 1'b0;
      last_n     = '0;
      cnt_n      = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      has_last   <= 1'b0;
      last       <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      has_last   <= has_last_n;
      last       <= last_n;
      cnt        <= cnt_n;
      flush_pend <= flush_pend_n;
      flush_done <= flush_serv;
    end
  end

  rle_out_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_num   (wr_num),
    .wr_data0 (wd[0]),
    .wr_data1 (wd[1]),
    .rd_en    (readyOut),
    .rd_data  (fifo_data),
    .rd_valid (fifo_valid),
    .free     (free)
  );

  assign flushDone = flush_done;
  assign validOut  = fifo_valid && reset_n;
  assign dataOut   = validOut ? fifo_data : '0;

`ifdef RLE_STATS_EN
  logic [31:0] stat_samples;
  logic [31:0] stat_words;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_samples <= '0;
      stat_words   <= '0;
    end else if (enable) begin
      if (take) begin
        stat_samples <= stat_samples + 32'd1;
      end
      if (validOut && readyOut) begin
        stat_words <= stat_words + 32'd1;
      end
    end
  end

  assign statSamples = stat_samples;
  assign statWords   = stat_words;
`else
  assign statSamples = '0;
  assign statWords   = '0;
`endif

endmodule
